vga_text_vram_arbiter: RTL and testbench
========================================

# vga_text_vram_arbiter

- Shares the single-port text character RAM between two requesters:
  - the VGA text display path, which reads one character code per 16x16 cell of the 40x30 grid;
  - the CPU peripheral bus, which reads and writes character codes.
- Sits between the timing generator's cell index output and the character/font lookup.
- Display fetches have strict priority. CPU accesses use a req/ack handshake and fill the idle slots.

## Interface
Parameters:
- ADDR_WIDTH, 11, width of cell addresses.
- DATA_WIDTH, 8, width of a character code.
- CELLS, 1200, number of valid cells (40x30). Addresses >= CELLS are out of range.

Ports:
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  reset: asynchronous, active-low.
- disp_active  in  1  display wants fetches.
- disp_addr  in  ADDR_WIDTH  cell index to fetch. Upstream supplies it with lookahead.
- disp_char  out  DATA_WIDTH  fetched character code.
- disp_valid  out  1  disp_char matches the current disp_addr.
- cpu_req  in  1  CPU request. Must be held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read. Sampled with cpu_addr and cpu_wdata at grant.
- cpu_addr  in  ADDR_WIDTH  CPU cell address.
- cpu_wdata  in  DATA_WIDTH  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_WIDTH  read data. Valid while cpu_ack is high.
- cpu_err  out  1  address out of range. Valid while cpu_ack is high.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_rdata  in  DATA_WIDTH  RAM read data. Synchronous RAM, 1-cycle read latency.

## Operation
- FSM states: IDLE, DISP_ISSUE, DISP_WAIT, CPU_ISSUE, CPU_DONE.
- Tracking registers:
  - last_addr: address of the last display fetch issued.
  - last_ok: last_addr is meaningful. Cleared at reset.
- disp_pending = disp_active & (~last_ok | disp_addr != last_addr).
- IDLE transitions:
  - disp_pending: latch disp_addr into last_addr, set last_ok, go to DISP_ISSUE.
  - else if cpu_req & ~cpu_ack: latch cpu_we, cpu_addr and cpu_wdata, go to CPU_ISSUE.
  - else stay in IDLE.
- DISP_ISSUE: ram_addr = last_addr, ram_we = 0. Next state DISP_WAIT.
- DISP_WAIT: capture ram_rdata into disp_char. Set disp_valid only if disp_addr still equals last_addr. Next state IDLE.
- Display out-of-range address (last_addr >= CELLS):
  - No RAM access.
  - DISP_WAIT loads disp_char = 0 and disp_valid = 1.
- CPU_ISSUE:
  - In range: drive ram_addr, and ram_we / ram_wdata from the latched request.
  - Out of range: ram_we forced to 0.
  - Next state CPU_DONE.
- CPU_DONE:
  - Register cpu_ack = 1.
  - cpu_rdata = ram_rdata for an in-range read, otherwise 0.
  - cpu_err = 1 if the address is out of range.
  - Next state IDLE.
- ram_addr, ram_we and ram_wdata are decoded combinationally from state and the latched registers. ram_we is 0 in every state except CPU_ISSUE for an in-range write.
- disp_valid clears in the cycle after disp_addr differs from last_addr. It stays 0 until the refetch completes.
- disp_addr changing during DISP_ISSUE or DISP_WAIT: the capture does not set disp_valid, and disp_pending forces a refetch from IDLE.
- disp_active low: no new display fetches. disp_char and disp_valid hold their values.

## Timing
- Reset values:
  - state IDLE, last_ok 0.
  - disp_char 0, disp_valid 0.
  - cpu_ack 0, cpu_rdata 0, cpu_err 0.
  - ram_we 0, ram_addr 0, ram_wdata 0.
- rst_n asserted mid-operation:
  - Takes effect immediately.
  - An in-flight CPU write is dropped if its CPU_ISSUE cycle has not completed.
  - No cpu_ack is generated for an aborted request.
- Uncontended CPU access: cpu_req seen in IDLE at cycle 0 → CPU_ISSUE at cycle 1 → CPU_DONE at cycle 2 → cpu_ack high in cycle 3 only.
- cpu_req is ignored in the cycle cpu_ack is high, so no double grant occurs. The requester drops cpu_req in the ack cycle or issues a new request afterwards.
- Display fetch: disp_addr change seen at cycle 0 → disp_char and disp_valid updated in cycle 3.
- Worst-case latencies, given disp_addr changes at most once per 32 clk (one cell):
  - display: 5 cycles, when a CPU access is in progress.
  - CPU grant: 3 cycles.
- Simultaneous disp_pending and cpu_req in IDLE: the display wins. The CPU is granted on the next IDLE cycle.

## Test plan
- CPU write 0x41 to address 5, then read address 5 → first cpu_ack in cycle 3, second read ack returns cpu_rdata = 0x41, cpu_err = 0, and ram_we is high only in the write's CPU_ISSUE cycle.
- CPU read address 1200 → cpu_ack in cycle 3 with cpu_err = 1 and cpu_rdata = 0, ram_we never asserted. CPU write to 2047 leaves RAM contents unchanged.
- RAM preloaded with mem[i] = i[7:0], disp_active = 1, disp_addr stepped 0 to 39 every 32 clk → each disp_char = i with disp_valid = 1 within 3 cycles of the change. disp_addr = 1329 → disp_char 0, disp_valid 1.
- cpu_req and a disp_addr change in the same cycle → display fetch first, cpu_ack 3 cycles later than the uncontended case, and both data values correct.
- disp_addr changed again during DISP_WAIT → disp_valid stays 0, a second fetch is issued, and the final disp_char matches the new address.
- rst_n pulsed low during CPU_ISSUE of a write → all outputs return to reset values asynchronously, no cpu_ack is produced, and a later read of that address returns the old contents.

Source files
------------

// File: rtl/vga_text_vram_arbiter.sv
// vga_text_vram_arbiter: shares the text RAM between display fetches (priority) and CPU req/ack accesses.
module vga_text_vram_arbiter #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int CELLS = 1200
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  disp_active,
  input  logic [ADDR_WIDTH-1:0] disp_addr,
  output logic [DATA_WIDTH-1:0] disp_char,
  output logic                  disp_valid,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_err,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);
  localparam logic [2:0] IDLE = 3'd0, DISP_ISSUE = 3'd1, DISP_WAIT = 3'd2, CPU_ISSUE = 3'd3, CPU_DONE = 3'd4;
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(CELLS);
  logic [2:0] state;
  logic [ADDR_WIDTH-1:0] last_addr, c_addr;
  logic [DATA_WIDTH-1:0] c_wdata;
  logic last_ok, c_we, disp_in, c_in, addr_moved, disp_pending;
  assign disp_in = {1'b0, last_addr} < LIMIT;
  assign c_in = {1'b0, c_addr} < LIMIT;
  assign addr_moved = disp_addr != last_addr;
  assign disp_pending = disp_active & (~last_ok | addr_moved);
  always_comb begin
    ram_addr = (state == DISP_ISSUE && disp_in) ? last_addr : (state == CPU_ISSUE && c_in) ? c_addr : '0;
    ram_we = state == CPU_ISSUE && c_in && c_we;
    ram_wdata = ram_we ? c_wdata : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last_addr <= '0;
      last_ok <= 1'b0;
      c_we <= 1'b0;
      c_addr <= '0;
      c_wdata <= '0;
      disp_char <= '0;
      disp_valid <= 1'b0;
      cpu_ack <= 1'b0;
      cpu_rdata <= '0;
      cpu_err <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      // a moved cell invalidates the shown character until its refetch lands
      if (disp_active && last_ok && addr_moved) disp_valid <= 1'b0;
      case (state)
        IDLE:
          if (disp_pending) begin
            last_addr <= disp_addr;
            last_ok <= 1'b1;
            state <= DISP_ISSUE;
          end else if (cpu_req && !cpu_ack) begin
            c_we <= cpu_we;
            c_addr <= cpu_addr;
            c_wdata <= cpu_wdata;
            state <= CPU_ISSUE;
          end
        DISP_ISSUE: state <= DISP_WAIT;
        DISP_WAIT: begin
          disp_char <= disp_in ? ram_rdata : '0;
          disp_valid <= !addr_moved;
          state <= IDLE;
        end
        CPU_ISSUE: state <= CPU_DONE;
        CPU_DONE: begin
          cpu_ack <= 1'b1;
          cpu_rdata <= (c_in && !c_we) ? ram_rdata : '0;
          cpu_err <= !c_in;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vga_text_vram_arbiter.sv
// tb_vga_text_vram_arbiter: directed vectors for the display/CPU text RAM arbiter.
module tb_vga_text_vram_arbiter;
  logic clk = 1'b0, rst_n = 1'b0, load = 1'b0;
  logic disp_active = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [10:0] disp_addr = '0, cpu_addr = '0, ram_addr;
  logic [7:0] cpu_wdata = '0, disp_char, cpu_rdata, ram_wdata, ram_rdata;
  logic disp_valid, cpu_ack, cpu_err, ram_we;
  logic [7:0] mem [0:2047];
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  vga_text_vram_arbiter dut (
    .clk(clk), .rst_n(rst_n), .disp_active(disp_active), .disp_addr(disp_addr),
    .disp_char(disp_char), .disp_valid(disp_valid), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .cpu_err(cpu_err), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 2048; i++) mem[i] <= i[7:0];
    end else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end
  typedef struct {
    logic we;
    logic [10:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic err;
    int wes;
  } cpu_vec_t;
  cpu_vec_t tbl [8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, " disp_char"}, 32'(disp_char), 32'h0);
    chk({tag, " disp_valid"}, 32'(disp_valid), 32'h0);
    chk({tag, " cpu_ack"}, 32'(cpu_ack), 32'h0);
    chk({tag, " cpu_rdata"}, 32'(cpu_rdata), 32'h0);
    chk({tag, " cpu_err"}, 32'(cpu_err), 32'h0);
    chk({tag, " ram_we"}, 32'(ram_we), 32'h0);
    chk({tag, " ram_addr"}, 32'(ram_addr), 32'h0);
    chk({tag, " ram_wdata"}, 32'(ram_wdata), 32'h0);
  endtask
  task automatic wait_valid(output int n);
    n = 11;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (disp_valid) begin
        n = k;
        break;
      end
    end
  endtask
  task automatic cpu_xfer(input logic we, input logic [10:0] a, input logic [7:0] d,
                          output int lat, output logic [7:0] rd, output logic er, output int wes);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    lat = 99; rd = 8'hxx; er = 1'bx; wes = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (ram_we) wes++;
      if (cpu_ack) begin
        lat = k; rd = cpu_rdata; er = cpu_err;
        break;
      end
    end
    cpu_req = 1'b0;
  endtask
  initial begin
    int n, lat, wes, dn, an, acks;
    logic [7:0] rd, dc;
    logic er;
    tbl[0] = '{1'b1, 11'd5,    8'h41, 8'h00, 1'b0, 1};
    tbl[1] = '{1'b0, 11'd5,    8'h00, 8'h41, 1'b0, 0};
    tbl[2] = '{1'b0, 11'd1200, 8'h00, 8'h00, 1'b1, 0};
    tbl[3] = '{1'b1, 11'd2047, 8'h99, 8'h00, 1'b1, 0};
    tbl[4] = '{1'b0, 11'd1199, 8'h00, 8'hAF, 1'b0, 0};
    tbl[5] = '{1'b1, 11'd0,    8'h7E, 8'h00, 1'b0, 1};
    tbl[6] = '{1'b0, 11'd0,    8'h00, 8'h7E, 1'b0, 0};
    tbl[7] = '{1'b0, 11'd10,   8'h00, 8'h0A, 1'b0, 0};
    load = 1'b1;
    repeat (2) @(posedge clk);
    load = 1'b0;
    @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      disp_addr = 11'(i); disp_active = 1'b1;
      wait_valid(n);
      chk($sformatf("disp lat %0d", i), 32'(n), 32'd3);
      chk($sformatf("disp char %0d", i), 32'(disp_char), 32'(i));
      repeat (28) @(negedge clk);
    end
    @(negedge clk);
    disp_addr = 11'd1329;
    wait_valid(n);
    chk("disp oor lat", 32'(n), 32'd3);
    chk("disp oor char", 32'(disp_char), 32'h0);
    @(negedge clk);
    disp_active = 1'b0; disp_addr = 11'd7;
    repeat (5) @(negedge clk);
    chk("inactive hold valid", 32'(disp_valid), 32'd1);
    chk("inactive hold char", 32'(disp_char), 32'h0);
    for (int i = 0; i < 8; i++) begin
      cpu_xfer(tbl[i].we, tbl[i].addr, tbl[i].wdata, lat, rd, er, wes);
      chk($sformatf("cpu lat %0d", i), 32'(lat), 32'd3);
      chk($sformatf("cpu rdata %0d", i), 32'(rd), 32'(tbl[i].rdata));
      chk($sformatf("cpu err %0d", i), 32'(er), 32'(tbl[i].err));
      chk($sformatf("cpu ram_we count %0d", i), 32'(wes), 32'(tbl[i].wes));
    end
    chk("oor write leaves ram", 32'(mem[2047]), 32'hFF);
    @(negedge clk);
    disp_addr = 11'd20; disp_active = 1'b1;
    wait_valid(n);
    chk("settle char 20", 32'(disp_char), 32'h14);
    repeat (3) @(negedge clk);
    disp_addr = 11'd21;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'd5;
    dn = 0; an = 0; dc = 8'h00; rd = 8'h00;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (dn == 0 && disp_valid) begin
        dn = k; dc = disp_char;
      end
      if (an == 0 && cpu_ack) begin
        an = k; rd = cpu_rdata; cpu_req = 1'b0;
      end
      if (dn != 0 && an != 0) break;
    end
    cpu_req = 1'b0;
    chk("contend disp lat", 32'(dn), 32'd3);
    chk("contend disp char", 32'(dc), 32'h15);
    chk("contend cpu lat", 32'(an), 32'd6);
    chk("contend cpu rdata", 32'(rd), 32'h41);
    repeat (3) @(negedge clk);
    disp_addr = 11'd22;
    repeat (2) @(negedge clk);
    disp_addr = 11'd23;
    @(negedge clk);
    chk("refetch valid low", 32'(disp_valid), 32'd0);
    wait_valid(n);
    chk("refetch lat", 32'(n), 32'd3);
    chk("refetch char", 32'(disp_char), 32'h17);
    @(negedge clk);
    disp_active = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'd9; cpu_wdata = 8'hEE;
    @(negedge clk);
    chk("abort in issue", 32'(ram_we), 32'd1);
    #1;
    rst_n = 1'b0; cpu_req = 1'b0;
    #1;
    chk_reset("async reset");
    acks = 0;
    repeat (2) begin
      @(negedge clk);
      if (cpu_ack) acks++;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (cpu_ack) acks++;
    end
    chk("aborted no ack", 32'(acks), 32'd0);
    cpu_xfer(1'b0, 11'd9, 8'h00, lat, rd, er, wes);
    chk("after abort lat", 32'(lat), 32'd3);
    chk("after abort rdata", 32'(rd), 32'h09);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
